// File: rtl/pre_i_pkg.sv
// pre_i_pkg: shared constants and types for the pre-intra gradient analyser.
//   COST_W / PIX_W  : accumulator and pixel widths
//   SAD_W           : width of one 8-pair absolute-difference sum (8*255 < 2^11)
//   MODE_*          : HEVC intra mode numbers emitted on mode_o
//   state_e         : controller states
//   row_t           : one 8-pixel row, element [c] is column c
package pre_i_pkg;

  localparam int unsigned COST_W = 14;
  localparam int unsigned PIX_W  = 8;
  localparam int unsigned SAD_W  = 11;

  localparam logic [5:0] MODE_DC   = 6'd1;
  localparam logic [5:0] MODE_H    = 6'd10;
  localparam logic [5:0] MODE_V    = 6'd26;
  localparam logic [5:0] MODE_D135 = 6'd18;
  localparam logic [5:0] MODE_D45  = 6'd34;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_DECIDE = 2'd2
  } state_e;

  typedef logic [7:0][PIX_W-1:0] row_t;

endpackage

// File: rtl/pre_i_absdiff_sum.sv
// pre_i_absdiff_sum: sum of |a[i]-b[i]| over the enabled pixel pairs.
//   a_i, b_i : eight 8-bit pixels each
//   en_i     : per-pair enable; disabled pairs contribute nothing
//   sum_o    : 11-bit sum (cannot overflow for 8 pairs)
module pre_i_absdiff_sum
  import pre_i_pkg::*;
(
  input  row_t             a_i,
  input  row_t             b_i,
  input  logic [7:0]       en_i,
  output logic [SAD_W-1:0] sum_o
);

  always_comb begin
    sum_o = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (en_i[i]) begin
        if (a_i[i] >= b_i[i]) sum_o = sum_o + SAD_W'(a_i[i] - b_i[i]);
        else                  sum_o = sum_o + SAD_W'(b_i[i] - a_i[i]);
      end
    end
  end

endmodule

// File: rtl/pre_i_grad8x8.sv
// pre_i_grad8x8: captures one 8x8 original-pixel block (16 four-pixel words),
// accumulates horizontal/vertical gradient costs and the pixel sum one row per
// cycle, then picks a candidate HEVC intra mode.
//   clk, rstn      : clock, asynchronous active-low reset
//   clr_i          : synchronous abort, back to IDLE without done
//   wr_en_i/addr/data : pixel word writes (addr[3:1] row, addr[0] half-row,
//                    data[31:24] leftmost pixel)
//   blk_idx_i      : block index, latched with the addr-15 write
//   busy_o         : CALC or DECIDE in progress
//   done_o         : one-cycle pulse, result outputs updated
//   mode_o, cost_h_o, cost_v_o, mean_o, blk_idx_o : registered result
//   err_o          : pulse, a write arrived while busy and was dropped
// Build option: define PRE_I_DIAG_EN to add the two diagonal costs and make
// modes 18/34 selectable.
module pre_i_grad8x8
  import pre_i_pkg::*;
#(
  parameter int unsigned FLAT_THR = 256
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        clr_i,
  input  logic        wr_en_i,
  input  logic [3:0]  wr_addr_i,
  input  logic [31:0] wr_data_i,
  input  logic [6:0]  blk_idx_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [5:0]  mode_o,
  output logic [13:0] cost_h_o,
  output logic [13:0] cost_v_o,
  output logic [7:0]  mean_o,
  output logic [6:0]  blk_idx_o,
  output logic        err_o
);

  localparam logic [COST_W:0] FLAT_THR_W = FLAT_THR[COST_W:0];

  state_e              state_q, state_d;
  logic [2:0]          row_q, row_d;
  row_t                pix_q [8];
  row_t                pix_d [8];
  logic [COST_W-1:0]   h_acc_q, h_acc_d, v_acc_q, v_acc_d;
  logic [COST_W:0]     sum_acc_q, sum_acc_d;
  logic [6:0]          blk_lat_q, blk_lat_d;
  logic [5:0]          mode_q, mode_d;
  logic [COST_W-1:0]   cost_h_q, cost_h_d, cost_v_q, cost_v_d;
  logic [PIX_W-1:0]    mean_q, mean_d;
  logic [6:0]          blk_out_q, blk_out_d;
  logic                done_q, done_d, err_q, err_d;

  row_t                cur_row, prev_row, cur_shift;
  logic [7:0]          v_en;
  logic [SAD_W-1:0]    h_sad, v_sad, row_sum;
  logic [2:0]          wcol;
  logic [COST_W:0]     hv_sum;
  logic [COST_W-1:0]   best_cost;
  logic [5:0]          dec_mode;

  // Row k is compared with itself shifted by one column (H) and with row
  // k-1 (V); row 0 has no predecessor, so V pairs are masked off then.
  assign cur_row   = pix_q[row_q];
  assign prev_row  = pix_q[row_q - 3'd1];
  assign cur_shift = {{PIX_W{1'b0}}, cur_row[7:1]};
  assign v_en      = (row_q != 3'd0) ? 8'hFF : 8'h00;

  pre_i_absdiff_sum u_sad_h (
    .a_i  (cur_row),
    .b_i  (cur_shift),
    .en_i (8'h7F),
    .sum_o(h_sad)
  );

  pre_i_absdiff_sum u_sad_v (
    .a_i  (cur_row),
    .b_i  (prev_row),
    .en_i (v_en),
    .sum_o(v_sad)
  );

`ifdef PRE_I_DIAG_EN
  row_t              prev_shift;
  logic [SAD_W-1:0]  d45_sad, d135_sad;
  logic [COST_W-1:0] d45_acc_q, d45_acc_d, d135_acc_q, d135_acc_d;

  assign prev_shift = {{PIX_W{1'b0}}, prev_row[7:1]};

  // D45 pairs p[k][c] with p[k-1][c+1]; D135 pairs p[k][c+1] with p[k-1][c].
  pre_i_absdiff_sum u_sad_d45 (
    .a_i  (cur_row),
    .b_i  (prev_shift),
    .en_i (v_en & 8'h7F),
    .sum_o(d45_sad)
  );

  pre_i_absdiff_sum u_sad_d135 (
    .a_i  (cur_shift),
    .b_i  (prev_row),
    .en_i (v_en & 8'h7F),
    .sum_o(d135_sad)
  );
`endif

  always_comb begin
    row_sum = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      row_sum = row_sum + SAD_W'(cur_row[i]);
    end
  end

  // Strict less-than keeps the earlier candidate on ties: V, H, D135, D45.
  always_comb begin
    hv_sum    = {1'b0, h_acc_q} + {1'b0, v_acc_q};
    best_cost = v_acc_q;
    dec_mode  = MODE_V;
    if (h_acc_q < best_cost) begin
      best_cost = h_acc_q;
      dec_mode  = MODE_H;
    end
`ifdef PRE_I_DIAG_EN
    if (d135_acc_q < best_cost) begin
      best_cost = d135_acc_q;
      dec_mode  = MODE_D135;
    end
    if (d45_acc_q < best_cost) begin
      best_cost = d45_acc_q;
      dec_mode  = MODE_D45;
    end
`endif
    if (hv_sum < FLAT_THR_W) dec_mode = MODE_DC;
  end

  assign wcol = {wr_addr_i[0], 2'b00};

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    pix_d     = pix_q;
    h_acc_d   = h_acc_q;
    v_acc_d   = v_acc_q;
    sum_acc_d = sum_acc_q;
    blk_lat_d = blk_lat_q;
    mode_d    = mode_q;
    cost_h_d  = cost_h_q;
    cost_v_d  = cost_v_q;
    mean_d    = mean_q;
    blk_out_d = blk_out_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef PRE_I_DIAG_EN
    d45_acc_d  = d45_acc_q;
    d135_acc_d = d135_acc_q;
`endif

    if (clr_i) begin
      state_d   = ST_IDLE;
      row_d     = '0;
      h_acc_d   = '0;
      v_acc_d   = '0;
      sum_acc_d = '0;
`ifdef PRE_I_DIAG_EN
      d45_acc_d  = '0;
      d135_acc_d = '0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (wr_en_i) begin
            pix_d[wr_addr_i[3:1]][wcol]        = wr_data_i[31:24];
            pix_d[wr_addr_i[3:1]][wcol + 3'd1] = wr_data_i[23:16];
            pix_d[wr_addr_i[3:1]][wcol + 3'd2] = wr_data_i[15:8];
            pix_d[wr_addr_i[3:1]][wcol + 3'd3] = wr_data_i[7:0];
            if (wr_addr_i == 4'hF) begin
              blk_lat_d = blk_idx_i;
              state_d   = ST_CALC;
              row_d     = '0;
              h_acc_d   = '0;
              v_acc_d   = '0;
              sum_acc_d = '0;
`ifdef PRE_I_DIAG_EN
              d45_acc_d  = '0;
              d135_acc_d = '0;
`endif
            end
          end
        end
        ST_CALC: begin
          err_d     = wr_en_i;
          h_acc_d   = h_acc_q + {3'b000, h_sad};
          v_acc_d   = v_acc_q + {3'b000, v_sad};
          sum_acc_d = sum_acc_q + {4'b0000, row_sum};
`ifdef PRE_I_DIAG_EN
          d45_acc_d  = d45_acc_q + {3'b000, d45_sad};
          d135_acc_d = d135_acc_q + {3'b000, d135_sad};
`endif
          row_d = row_q + 3'd1;
          if (row_q == 3'd7) state_d = ST_DECIDE;
        end
        ST_DECIDE: begin
          err_d     = wr_en_i;
          cost_h_d  = h_acc_q;
          cost_v_d  = v_acc_q;
          mean_d    = PIX_W'(sum_acc_q >> 6);
          blk_out_d = blk_lat_q;
          mode_d    = dec_mode;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      for (int unsigned r = 0; r < 8; r++) pix_q[r] <= '0;
      h_acc_q   <= '0;
      v_acc_q   <= '0;
      sum_acc_q <= '0;
      blk_lat_q <= '0;
      mode_q    <= '0;
      cost_h_q  <= '0;
      cost_v_q  <= '0;
      mean_q    <= '0;
      blk_out_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef PRE_I_DIAG_EN
      d45_acc_q  <= '0;
      d135_acc_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      pix_q     <= pix_d;
      h_acc_q   <= h_acc_d;
      v_acc_q   <= v_acc_d;
      sum_acc_q <= sum_acc_d;
      blk_lat_q <= blk_lat_d;
      mode_q    <= mode_d;
      cost_h_q  <= cost_h_d;
      cost_v_q  <= cost_v_d;
      mean_q    <= mean_d;
      blk_out_q <= blk_out_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef PRE_I_DIAG_EN
      d45_acc_q  <= d45_acc_d;
      d135_acc_q <= d135_acc_d;
`endif
    end
  end

  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = done_q;
  assign mode_o    = mode_q;
  assign cost_h_o  = cost_h_q;
  assign cost_v_o  = cost_v_q;
  assign mean_o    = mean_q;
  assign blk_idx_o = blk_out_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_pre_i_grad8x8.sv
// tb_pre_i_grad8x8: directed bench for pre_i_grad8x8. A pixel model tracks
// every accepted write; expected results are queued at the addr-15 write and
// popped when done_o is seen. Honours PRE_I_DIAG_EN like the design.
module tb_pre_i_grad8x8;

  logic        clk = 1'b0;
  logic        rstn;
  logic        clr_i;
  logic        wr_en_i;
  logic [3:0]  wr_addr_i;
  logic [31:0] wr_data_i;
  logic [6:0]  blk_idx_i;
  logic        busy_o, done_o, err_o;
  logic [5:0]  mode_o;
  logic [13:0] cost_h_o, cost_v_o;
  logic [7:0]  mean_o;
  logic [6:0]  blk_idx_o;

  always #5 clk = ~clk;

  pre_i_grad8x8 #(.FLAT_THR(256)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .clr_i    (clr_i),
    .wr_en_i  (wr_en_i),
    .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i),
    .blk_idx_i(blk_idx_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .mode_o   (mode_o),
    .cost_h_o (cost_h_o),
    .cost_v_o (cost_v_o),
    .mean_o   (mean_o),
    .blk_idx_o(blk_idx_o),
    .err_o    (err_o)
  );

  typedef struct {
    int h;
    int v;
    int mean;
    int mode;
    int blk;
  } exp_t;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] mdl [8][8];
  int         pat [8][8];
  exp_t       sb [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic exp_t model_expect(input int blk);
    exp_t e;
    int   sum, best, d45, d135;
    e.h = 0; e.v = 0; sum = 0; d45 = 0; d135 = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        sum += mdl[r][c];
        if (c < 7) e.h += absd(mdl[r][c+1], mdl[r][c]);
        if (r < 7) e.v += absd(mdl[r+1][c], mdl[r][c]);
        if (r < 7 && c < 7) begin
          d45  += absd(mdl[r+1][c], mdl[r][c+1]);
          d135 += absd(mdl[r+1][c+1], mdl[r][c]);
        end
      end
    e.mean = sum / 64;
    e.blk  = blk;
    best = e.v; e.mode = 26;
    if (e.h < best) begin best = e.h; e.mode = 10; end
`ifdef PRE_I_DIAG_EN
    if (d135 < best) begin best = d135; e.mode = 18; end
    if (d45 < best) begin best = d45; e.mode = 34; end
`endif
    if (e.h + e.v < 256) e.mode = 1;
    return e;
  endfunction

  task automatic set_pat(input int kind);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        case (kind)
          0: pat[r][c] = 128;
          1: pat[r][c] = 20 * c;
          2: pat[r][c] = 20 * r;
          3: pat[r][c] = 16 * (r + c);
          5: pat[r][c] = ((r + c) % 2 == 1) ? 255 : 0;
          6: pat[r][c] = (r == 0 && c == 0) ? 128 : 0;
          7: pat[r][c] = (r == 0 && c < 2) ? 85 : 0;
          default: pat[r][c] = int'($urandom_range(0, 255));
        endcase
  endtask

  // Writes the 16 words on consecutive cycles; blk_idx_i only carries the
  // real index on the addr-15 write.
  task automatic fill(input logic [6:0] blk, input bit expect_result);
    int r, b;
    for (int w = 0; w < 16; w++) begin
      @(negedge clk);
      r = w / 2;
      b = (w % 2) * 4;
      for (int j = 0; j < 4; j++) mdl[r][b+j] = 8'(pat[r][b+j]);
      wr_en_i   = 1'b1;
      wr_addr_i = 4'(w);
      wr_data_i = {mdl[r][b], mdl[r][b+1], mdl[r][b+2], mdl[r][b+3]};
      blk_idx_i = (w == 15) ? blk : (blk ^ 7'h55);
    end
    if (expect_result) sb.push_back(model_expect(int'(blk)));
  endtask

  // k counts cycles after the addr-15 write edge (cycle t+k).
  task automatic run_calc(input int err_at, input int clr_at, input string tag);
    int   got;
    exp_t e;
    got = 0;
    e = '{default: 0};
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      wr_en_i = 1'b0;
      clr_i   = 1'b0;
      if (done_o === 1'b1) begin
        got++;
        check({tag, ".latency"}, k, 10);
        check({tag, ".sb_nonempty"}, sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check({tag, ".cost_h"}, cost_h_o, e.h);
          check({tag, ".cost_v"}, cost_v_o, e.v);
          check({tag, ".mean"},   mean_o,   e.mean);
          check({tag, ".mode"},   mode_o,   e.mode);
          check({tag, ".blk"},    blk_idx_o, e.blk);
        end
      end
      if (k == 1) check({tag, ".busy_t1"}, busy_o, 1);
      if (clr_at == 0 && k == 9)  check({tag, ".busy_t9"}, busy_o, 1);
      if (clr_at == 0 && k == 10) check({tag, ".busy_t10"}, busy_o, 0);
      if (clr_at == 0 && k == 12 && got == 1) begin
        check({tag, ".hold_h"}, cost_h_o, e.h);
        check({tag, ".hold_mode"}, mode_o, e.mode);
      end
      if (err_at != 0 && k == err_at + 1) check({tag, ".err_pulse"}, err_o, 1);
      if (err_at != 0 && k == err_at + 2) check({tag, ".err_end"}, err_o, 0);
      if (clr_at != 0 && k == clr_at + 1) check({tag, ".busy_after_clr"}, busy_o, 0);
      if (err_at != 0 && k == err_at) begin
        wr_en_i   = 1'b1;
        wr_addr_i = 4'd3;
        wr_data_i = ~{mdl[1][4], mdl[1][5], mdl[1][6], mdl[1][7]};
      end
      if (clr_at != 0 && k == clr_at) clr_i = 1'b1;
    end
    check({tag, ".done_count"}, got, (clr_at == 0) ? 1 : 0);
  endtask

  initial begin
    int got;
    rstn = 1'b0; clr_i = 1'b0; wr_en_i = 1'b0;
    wr_addr_i = '0; wr_data_i = '0; blk_idx_i = '0;
    repeat (3) @(negedge clk);
    check("rst.done",  done_o, 0);
    check("rst.busy",  busy_o, 0);
    check("rst.err",   err_o, 0);
    check("rst.mode",  mode_o, 0);
    check("rst.cost_h", cost_h_o, 0);
    check("rst.cost_v", cost_v_o, 0);
    check("rst.mean",  mean_o, 0);
    check("rst.blk",   blk_idx_o, 0);
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst.busy", busy_o, 0);

    set_pat(0); fill(7'd5,  1'b1); run_calc(0, 0, "flat128");
    set_pat(1); fill(7'd6,  1'b1); run_calc(0, 0, "hramp");
    set_pat(2); fill(7'd7,  1'b1); run_calc(0, 0, "vramp");
    set_pat(3); fill(7'd8,  1'b1); run_calc(0, 0, "diag");
    set_pat(5); fill(7'd9,  1'b1); run_calc(0, 0, "checker");
    set_pat(6); fill(7'd10, 1'b1); run_calc(0, 0, "thr256");
    set_pat(7); fill(7'd11, 1'b1); run_calc(0, 0, "thr255");
    set_pat(4); fill(7'd12, 1'b1); run_calc(4, 0, "errwr");
    set_pat(4); fill(7'd13, 1'b0); run_calc(0, 5, "clr");
    set_pat(4); fill(7'd14, 1'b1); run_calc(0, 0, "afterclr");

    // clr together with an addr-15 write: the write must not start a block.
    @(negedge clk);
    wr_en_i = 1'b1; wr_addr_i = 4'hF; wr_data_i = 32'h01020304;
    blk_idx_i = 7'd99; clr_i = 1'b1;
    @(negedge clk);
    wr_en_i = 1'b0; clr_i = 1'b0;
    check("clrwr.busy", busy_o, 0);
    got = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_o === 1'b1) got++;
    end
    check("clrwr.no_done", got, 0);

    set_pat(4); fill(7'd127, 1'b1); run_calc(0, 0, "rand2");
    check("sb.drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
